// File: rtl/pbr_event_ctrl.sv
// ============================================================================
// Module      : pbr_event_ctrl
// Description : Pushbutton synchronizer/debouncer with an edge-event FIFO,
//               Wishbone register access and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pbr_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_inta_o,
  input  logic [4:0]  ext_pbr_i
);

  localparam int c_cw   = $clog2(DEBOUNCE_CYCLES);
  localparam int c_aw   = $clog2(FIFO_DEPTH);
  localparam int c_cntw = c_aw + 1;
  localparam logic [c_cw-1:0]   c_cnt_max = c_cw'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cntw-1:0] c_depth   = c_cntw'(FIFO_DEPTH);

  logic [4:0]        r_sync1, r_sync2, r_deb_d, r_pending, r_etype;
  logic [4:0]        w_deb, w_press, w_rel, w_qual, w_new, w_sel_oh;
  logic [2:0]        w_sel_idx, w_adr;
  logic [4:0]        r_press_en, r_rel_en;
  logic              r_irq_en, r_ovf, r_ack, r_inta;
  logic [31:0]       r_dat, w_rdata;
  logic [3:0]        r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wptr, r_rptr;
  logic [c_cntw-1:0] r_count;
  logic              w_acc, w_wr, w_rd, w_flush, w_empty, w_full, w_pop, w_push, w_coll;
  logic [3:0]        w_head;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb_d <= '0;
    end else begin
      r_sync1 <= ext_pbr_i;
      r_sync2 <= r_sync1;
      r_deb_d <= w_deb;
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    logic [c_cw-1:0] r_cnt;
    logic            r_lvl;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync2[gi] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_lvl <= ~r_lvl;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_deb[gi] = r_lvl;
  end

  // Edges are seen one cycle after the debounced flip, via the delayed copy.
  assign w_press = w_deb & ~r_deb_d & r_press_en;
  assign w_rel   = ~w_deb & r_deb_d & r_rel_en;
  assign w_qual  = w_press | w_rel;
  assign w_new   = w_qual & ~r_pending;
  assign w_coll  = |(w_qual & r_pending);

  always_comb begin
    w_sel_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (r_pending[i]) w_sel_idx = 3'(i);
    end
  end
  assign w_sel_oh = 5'b00001 << w_sel_idx;

  assign w_adr   = wb_adr_i[4:2];
  assign w_acc   = ~r_ack & wb_cyc_i & wb_stb_i;
  assign w_wr    = w_acc & wb_we_i;
  assign w_rd    = w_acc & ~wb_we_i;
  assign w_flush = w_wr & (w_adr == 3'd1) & wb_dat_i[31];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);
  assign w_pop   = w_rd & (w_adr == 3'd2) & ~w_empty;
  assign w_push  = (|r_pending) & (~w_full | w_pop) & ~w_flush;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr] <= {r_etype[w_sel_idx], w_sel_idx};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_etype   <= '0;
    end else begin
      r_etype <= (r_etype & ~w_new) | (w_press & w_new);
      if (w_flush) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_count   <= '0;
        r_pending <= '0;
      end else begin
        r_pending <= (r_pending & ~(w_push ? w_sel_oh : 5'b0)) | w_new;
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      3'd0: w_rdata = {27'b0, w_deb};
      3'd1: w_rdata = {15'b0, r_irq_en, 3'b0, r_rel_en, 3'b0, r_press_en};
      3'd2: w_rdata = w_empty ? 32'b0 : {1'b1, 26'b0, w_head[3], 1'b0, w_head[2:0]};
      3'd3: w_rdata = {21'b0, w_empty, w_full, r_ovf, 8'(r_count)};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_inta     <= 1'b0;
      r_press_en <= '0;
      r_rel_en   <= '0;
      r_irq_en   <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_ack  <= w_acc;
      r_inta <= r_irq_en & (~w_empty | r_ovf);
      if (w_rd) r_dat <= w_rdata;
      if (w_wr && w_adr == 3'd1) begin
        r_press_en <= wb_dat_i[4:0];
        r_rel_en   <= wb_dat_i[12:8];
        r_irq_en   <= wb_dat_i[16];
      end
      // A new collision outranks a simultaneous clear.
      if (w_coll) r_ovf <= 1'b1;
      else if (w_wr && w_adr == 3'd3 && wb_dat_i[8]) r_ovf <= 1'b0;
    end
  end

  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_dat;
  assign wb_inta_o = r_inta;
  assign wb_err_o  = 1'b0;

  logic w_unused;
  assign w_unused = &{1'b0, wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0],
                      wb_dat_i[30:17], wb_dat_i[15:13], wb_dat_i[7:5]};

endmodule

`default_nettype wire

// File: tb/tb_pbr_event_ctrl.sv
// Testbench for pbr_event_ctrl: directed scenarios plus randomized button
// activity checked against an event-level reference model.
`default_nettype none

module tb_pbr_event_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic [4:0]  ext;
  logic [31:0] dat_r;
  logic        ack, err, inta;
  int total = 0;
  int bad   = 0;

  pbr_event_ctrl #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(8)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_dat_o(dat_r), .wb_ack_o(ack), .wb_err_o(err), .wb_inta_o(inta),
    .ext_pbr_i(ext)
  );

  always #5 clk = ~clk;

  task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [31:0] wd,
                         output logic [31:0] rd);
    bit got = 0;
    cyc = 1; stb = 1; we = w; adr = {27'b0, a, 2'b00}; dat_w = wd; rd = '0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1; rd = dat_r; end
    end
    cyc = 0; stb = 0; we = 0;
    if (!got) begin
      total++; bad++;
      $display("FAIL bus_ack addr=%0d: no ack within 4 cycles", a);
    end
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    wb_xfer(1'b0, a, 32'h0, d);
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, dummy);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 0;
    for (int k = 0; k < 6; k++) begin
      ext = 5'($urandom);
      @(posedge clk); #1;
    end
    total++;
    if ({ack, err, inta} !== 3'b000) begin
      bad++; $display("FAIL reset_ctl: ack/err/inta=%b required 000", {ack, err, inta});
    end
    total++;
    if (dat_r !== 32'h0) begin
      bad++; $display("FAIL reset_dat: got %h required 0", dat_r);
    end
    ext = 0;
    settle(2);
    rst_n = 1;
    settle(2);
    wb_read(3'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_state: got %h required 0", d); end
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h400) begin bad++; $display("FAIL reset_status: got %h required 400", d); end
  endtask

  task automatic test_single_press();
    logic [31:0] d;
    wb_write(3'd1, 32'h0001_001F);
    ext = 5'b00100;
    settle(8);
    total++;
    if (inta !== 1'b0) begin bad++; $display("FAIL press_inta_early: got %b required 0", inta); end
    settle(1);
    total++;
    if (inta !== 1'b1) begin bad++; $display("FAIL press_inta_rise: got %b required 1", inta); end
    wb_read(3'd0, d);
    total++;
    if (d !== 32'h4) begin bad++; $display("FAIL press_state: got %h required 4", d); end
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL press_status: got %h required 1", d); end
    wb_read(3'd2, d);
    total++;
    if (d !== 32'h8000_0012) begin bad++; $display("FAIL press_event: got %h required 80000012", d); end
    total++;
    if (inta !== 1'b1) begin bad++; $display("FAIL press_inta_hold: got %b required 1", inta); end
    settle(1);
    total++;
    if (inta !== 1'b0) begin bad++; $display("FAIL press_inta_fall: got %b required 0", inta); end
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h400) begin bad++; $display("FAIL press_status_after: got %h required 400", d); end
    ext = 0;
    settle(12);
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    ext[0] = 1;
    settle(3);
    ext[0] = 0;
    settle(12);
    wb_read(3'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL bounce_state: got %h required 0", d); end
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h400) begin bad++; $display("FAIL bounce_status: got %h required 400", d); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic [31:0] exp [3] = '{32'h8000_0011, 32'h8000_0014, 32'h0};
    wb_write(3'd1, 32'h0001_001F);
    ext = 5'b10010;
    settle(12);
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL simul_status: got %h required 2", d); end
    for (int k = 0; k < 3; k++) begin
      wb_read(3'd2, d);
      total++;
      if (d !== exp[k]) begin bad++; $display("FAIL simul_event%0d: got %h required %h", k, d, exp[k]); end
    end
    ext = 0;
    settle(12);
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    wb_write(3'd1, 32'h0001_1F1F);
    for (int k = 0; k < 4; k++) begin
      ext[0] = 1; settle(8);
      ext[0] = 0; settle(8);
    end
    settle(4);
    ext[1] = 1; settle(8);
    ext[1] = 0; settle(12);
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h308) begin bad++; $display("FAIL ovf_status: got %h required 308", d); end
    total++;
    if (inta !== 1'b1) begin bad++; $display("FAIL ovf_inta: got %b required 1", inta); end
    wb_write(3'd3, 32'h100);
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h208) begin bad++; $display("FAIL ovf_clear: got %h required 208", d); end
    total++;
    if (inta !== 1'b1) begin bad++; $display("FAIL ovf_inta_nonempty: got %b required 1", inta); end
    for (int k = 0; k < 10; k++) begin
      if (k == 9)      e = 32'h0;
      else if (k == 8) e = 32'h8000_0011;
      else             e = (k % 2 == 0) ? 32'h8000_0010 : 32'h8000_0000;
      wb_read(3'd2, d);
      total++;
      if (d !== e) begin bad++; $display("FAIL ovf_drain%0d: got %h required %h", k, d, e); end
    end
    settle(1);
    total++;
    if (inta !== 1'b0) begin bad++; $display("FAIL ovf_inta_empty: got %b required 0", inta); end
  endtask

  task automatic test_flush_and_reset();
    logic [31:0] d;
    ext = 5'b11000;
    settle(12);
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL flush_pre: got %h required 2", d); end
    wb_write(3'd1, 32'h8001_1F1F);
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h400) begin bad++; $display("FAIL flush_status: got %h required 400", d); end
    wb_read(3'd1, d);
    total++;
    if (d !== 32'h0001_1F1F) begin bad++; $display("FAIL flush_ctrl: got %h required 00011f1f", d); end
    ext = 0;
    settle(12);
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL flush_release: got %h required 2", d); end
    cyc = 1; stb = 1; we = 0; adr = 32'h8;
    #2 rst_n = 0;
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL midreset_ack: got %b required 0", ack); end
    @(posedge clk); #1;
    total++;
    if ({ack, inta, dat_r} !== 34'h0) begin
      bad++; $display("FAIL midreset_out: ack=%b inta=%b dat=%h required all 0", ack, inta, dat_r);
    end
    cyc = 0; stb = 0;
    rst_n = 1;
    settle(2);
    wb_read(3'd3, d);
    total++;
    if (d !== 32'h400) begin bad++; $display("FAIL midreset_status: got %h required 400", d); end
    wb_read(3'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midreset_ctrl: got %h required 0", d); end
  endtask

  // Model: a level held for at least 4 samples becomes the debounced level;
  // each enabled debounced change produces one event, in time order.
  task automatic test_random();
    logic [4:0]  pen, ren, lvl;
    logic [31:0] q [$];
    logic [31:0] d, e;
    int          b, w;
    bit          rev;
    pen = 5'($urandom);
    ren = 5'($urandom);
    lvl = '0;
    wb_write(3'd1, {15'b0, 1'b1, 3'b0, ren, 3'b0, pen});
    for (int it = 0; it < 24; it++) begin
      b   = $urandom_range(0, 4);
      w   = $urandom_range(1, 7);
      rev = 1'($urandom_range(0, 1));
      ext[b] = ~ext[b];
      settle(w);
      if (rev) ext[b] = ~ext[b];
      settle(12);
      if (w >= 4 || !rev) begin
        for (int f = 0; f < (rev ? 2 : 1); f++) begin
          lvl[b] = ~lvl[b];
          if (lvl[b] ? pen[b] : ren[b])
            q.push_back(32'h8000_0000 | (lvl[b] ? 32'h10 : 32'h0) | 32'(b));
        end
      end
      wb_read(3'd0, d);
      total++;
      if (d !== {27'b0, lvl}) begin bad++; $display("FAIL rand_state it=%0d: got %h required %h", it, d, {27'b0, lvl}); end
      while (q.size() > 0) begin
        e = q.pop_front();
        wb_read(3'd2, d);
        total++;
        if (d !== e) begin bad++; $display("FAIL rand_event it=%0d: got %h required %h", it, d, e); end
      end
      wb_read(3'd2, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL rand_empty it=%0d: got %h required 0", it, d); end
    end
  endtask

  initial begin
    rst_n = 0; cyc = 0; stb = 0; we = 0; adr = 0; dat_w = 0; sel = 4'hF; ext = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_flush_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/pbr_event_ctrl.md
# pbr_event_ctrl

Pushbutton event controller for the SweRVolf SoC peripheral bus. It synchronizes and debounces the five board pushbuttons, then schedules per-button press/release edges into an event FIFO. Software reads that FIFO over a Wishbone slave port, and the block raises an interrupt while events are pending. It replaces raw level polling of the pushbutton register with interrupt-driven, loss-detecting event delivery.

## Interface
- DEBOUNCE_CYCLES, 500000, stable-input cycles required before a debounced level flips (5 ms at 100 MHz); must be ≥ 2.
- FIFO_DEPTH, 8, event FIFO entries; power of 2, 2..128.
- wb_clk_i  in  1  single clock, all logic rising-edge.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- wb_cyc_i  in  1  Wishbone cycle valid.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address; only [4:2] decoded.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects; ignored, all accesses are full-word.
- wb_dat_o  out  32  read data, valid while wb_ack_o=1.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  tied 0.
- wb_inta_o  out  1  interrupt request, level, registered.
- ext_pbr_i  in  5  raw asynchronous pushbuttons, 1 = pressed.

## Operation
- Input path: 2-flop synchronizer per button, then a per-button debounce counter of width $clog2(DEBOUNCE_CYCLES).
- Debounce: when sync ≠ debounced, the counter increments. When sync = debounced, the counter clears. When the counter = DEBOUNCE_CYCLES-1 and sync still differs, the debounced bit flips and the counter clears.
- Edge qualification: a 0→1 flip is a press and is qualified by CTRL.press_en[i]. A 1→0 flip is a release and is qualified by CTRL.rel_en[i].
- Each qualified edge sets pending[i] and records edge type etype[i].
- Scheduler: each cycle, if any pending bit is set and the FIFO is not full, push the entry for the lowest-index pending button {edge, idx[2:0]} and clear that pending bit. One push per cycle at most.
- Pending collision: a qualified edge on button i while pending[i]=1 drops the new edge and sets STATUS.ovf. pending[i] and etype[i] keep the old event.
- Register map (wb_adr_i[4:2]):
  - 0 STATE (RO): [4:0] debounced levels.
  - 1 CTRL (RW): [4:0] press_en, [12:8] rel_en, [16] irq_en. [31] flush is write-1, self-clearing, and reads 0; it empties the FIFO and clears all pending bits.
  - 2 EVENT (RO, pop): [31] valid, [4] edge (1=press), [2:0] idx, all other bits 0.
    - A read when not empty returns the head entry and pops it on the ack cycle.
    - A read when empty returns 0 and pops nothing.
  - 3 STATUS: [7:0] count (0..FIFO_DEPTH), [8] ovf (sticky, write-1-to-clear), [9] full, [10] empty.
  - 4–7: read 0; writes ignored.
  - Writes to RO registers are ignored.
- Interrupt: wb_inta_o is registered from irq_en & (!empty | ovf).
- Simultaneous push and pop in one cycle: both occur and count is unchanged; this is legal when full.
- Flush in the same cycle as a push: the flush wins and the push is discarded.

## Timing
- Reset values:
  - wb_ack_o=0, wb_dat_o=0, wb_inta_o=0, wb_err_o=0.
  - CTRL=0, STATUS.ovf=0; FIFO empty, pending=0.
  - Debounced levels=0, counters=0, synchronizers=0.
- Reset assertion clears all state immediately, including a transfer in flight; no ack is issued for it.
- Wishbone handshake: ack_next = !ack & cyc & stb. The ack is registered, so every access has exactly one wait state, including back-to-back accesses.
- wb_dat_o is registered on the same edge that raises ack and holds until the next acked read.
- Register writes and W1C bits take effect on the edge that raises ack.
- Latency, with an input change captured at edge 0:
  - Sync output changes at edge 2.
  - Debounced bit flips at edge 2+DEBOUNCE_CYCLES.
  - pending is set one edge later.
  - The FIFO push (count increment) happens one edge after that, if not full.
  - wb_inta_o rises one edge after the count changes.
- A pop updates count on the ack edge; wb_inta_o falls one edge later when the FIFO becomes empty and ovf=0.
- Debounce glitch: an input bounce shorter than DEBOUNCE_CYCLES resets the counter and produces no event.

## Test plan
(All scenarios use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=8.)
- Reset/idle: hold wb_rst_n_i=0 and toggle ext_pbr_i → all outputs 0. After release, a STATE read returns 0 and a STATUS read returns 0x400.
- Single press: write CTRL=0x0001001F, then hold ext_pbr_i=5'b00100 → STATE=0x4 at the edge 2+4 from capture, count=1 two edges later, inta=1. The EVENT read returns 0x80000012; count then returns 0 and inta=0.
- Bounce: pulse ext_pbr_i[0] high for 3 cycles → no STATE change, count stays 0.
- Simultaneous: set press_en=0x1F, then assert buttons 4 and 1 in the same cycle → two pushes on consecutive cycles. EVENT reads return 0x80000011, then 0x80000014, then 0.
- Overflow: fill with 8 presses/releases without reading, then generate 2 more edges on one button → full=1, ovf=1, count=8, one edge lost. Write STATUS bit 8 → ovf clears; inta stays 1 while not empty.
- Flush and reset mid-access: write CTRL[31]=1 with a nonempty FIFO → count=0 and pending cleared. Assert reset while stb is held and ack is pending → ack stays 0, FIFO empty.
